// File: rtl/uart_rx_deserializer_if.sv
// FIFO-side and status bundle of the UART receiver front-end.
// The receiver drives the write strobe, data and status pulses through the
// master modport; the RX FIFO / status logic sits on the slave modport and
// returns the FIFO full flag.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  WEo;
    logic [DATA_WIDTH-1:0] WDo;
    logic                  BUSYo;
    logic                  FRAME_ERRo;
    logic                  PARITY_ERRo;
    logic                  OVERRUNo;
    logic                  FULLi;

    modport master (
        output WEo,
        output WDo,
        output BUSYo,
        output FRAME_ERRo,
        output PARITY_ERRo,
        output OVERRUNo,
        input  FULLi
    );

    modport slave (
        input  WEo,
        input  WDo,
        input  BUSYo,
        input  FRAME_ERRo,
        input  PARITY_ERRo,
        input  OVERRUNo,
        output FULLi
    );
endinterface : uart_rx_deserializer_if

// File: rtl/uart_rx_deserializer.sv
// UART receiver front-end in the WCLK domain.
// Synchronises the asynchronous RXi line, finds the start bit, samples every
// bit at its centre (LSB first), optionally checks parity and, at the centre
// of the stop bit, either writes the byte into the RX FIFO or reports exactly
// one framing / parity / overrun pulse. All outputs are registered.
module uart_rx_deserializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                          WCLK,
    input  logic                          WRST,
    input  logic                          RXi,
    uart_rx_deserializer_if.master        fifo_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    // BREAK is the safe state after reset and after a framing error: a line
    // that is already low must first return high before a start is accepted.
    typedef enum logic [2:0] {
        ST_BREAK,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_e;

    // Synchroniser.
    logic rx_meta_q;
    logic rx_s_q;

    // FSM state and datapath.
    state_e                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [BIT_W-1:0]       bit_q,    bit_d;
    logic [DATA_WIDTH-1:0]  shift_q,  shift_d;
    logic                   perr_q,   perr_d;

    // Registered outputs.
    logic                   we_q,     we_d;
    logic [DATA_WIDTH-1:0]  wd_q,     wd_d;
    logic                   busy_q,   busy_d;
    logic                   ferr_q,   ferr_d;
    logic                   perr_o_q, perr_o_d;
    logic                   ovr_q,    ovr_d;

    // Two-flop synchroniser for the asynchronous serial line.
    // NOTE: the sync flops reset to 1 (idle line level) rather than 0 so that
    // leaving reset never looks like a falling edge; every other register
    // resets to 0.
    always_ff @(posedge WCLK or posedge WRST) begin
        if (WRST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make rx_s_q take the *old*
            // rx_meta_q, which is what gives the two-stage delay; blocking
            // here would collapse the chain into a single flop.
            rx_meta_q <= RXi;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge WCLK or posedge WRST) begin
        if (WRST) begin
            state_q  <= ST_BREAK;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            we_q     <= 1'b0;
            wd_q     <= '0;
            busy_q   <= 1'b0;
            ferr_q   <= 1'b0;
            perr_o_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            we_q     <= we_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            ferr_q   <= ferr_d;
            perr_o_q <= perr_o_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state, bit sampling and stop-bit decision.
    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves a variable unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        we_d     = 1'b0;
        wd_d     = wd_q;
        ferr_d   = 1'b0;
        perr_o_d = 1'b0;
        ovr_d    = 1'b0;

        unique case (state_q)
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end
            end

            // Re-check the start bit at its centre to reject short glitches.
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (rx_s_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            // Shift in from the top so the first (LSB) bit ends at bit 0.
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_q == DATA_LAST) begin
                        perr_d  = 1'b0;
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            // Parity outcome is held until the stop bit decides what to report.
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    perr_d  = ((^shift_q) ^ rx_s_q) != PARITY_ODD;
                    state_d = ST_STOP;
                end
            end

            // Decide at mid-stop and go back to IDLE straight away, leaving
            // half a bit of slack before the next start edge.
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end else if (perr_q) begin
                        perr_o_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (fifo_if.FULLi) begin
                        ovr_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        we_d    = 1'b1;
                        wd_d    = shift_q;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_BREAK;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign fifo_if.WEo         = we_q;
    assign fifo_if.WDo         = wd_q;
    assign fifo_if.BUSYo       = busy_q;
    assign fifo_if.FRAME_ERRo  = ferr_q;
    assign fifo_if.PARITY_ERRo = perr_o_q;
    assign fifo_if.OVERRUNo    = ovr_q;

endmodule : uart_rx_deserializer

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: one 8N1 instance and one 8E1
// instance, both at 16 clocks per bit. Stimulus pushes the expected event
// into a per-instance queue; a negedge monitor pops and compares whenever an
// instance raises a strobe or an error pulse.
module tb_uart_rx_deserializer;

    localparam int CPB = 16;

    typedef enum logic [1:0] {EV_WR, EV_FR, EV_PAR, EV_OVR} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] data;
    } ev_t;

    logic WCLK = 1'b0;
    logic WRST;
    logic rx_n;
    logic rx_p;

    uart_rx_deserializer_if #(.DATA_WIDTH(8)) if_n ();
    uart_rx_deserializer_if #(.DATA_WIDTH(8)) if_p ();

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
    ) dut_n (
        .WCLK(WCLK), .WRST(WRST), .RXi(rx_n), .fifo_if(if_n.master)
    );

    uart_rx_deserializer #(
        .CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
    ) dut_p (
        .WCLK(WCLK), .WRST(WRST), .RXi(rx_p), .fifo_if(if_p.master)
    );

    always #5 WCLK = ~WCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_we_cyc_n = -1;

    ev_t exp_n[$];
    ev_t exp_p[$];

    always @(posedge WCLK) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare one instance's outputs against the head of its queue.
    task automatic observe(input bit sel, input logic we, input logic [7:0] wd,
                           input logic fe, input logic pe, input logic ov);
        int       cnt;
        ev_kind_e kind;
        ev_t      e;
        cnt = int'(we) + int'(fe) + int'(pe) + int'(ov);
        if (cnt > 1) check(sel ? "p_exclusive" : "n_exclusive", cnt, 1);
        if (cnt == 0) return;
        kind = we ? EV_WR : fe ? EV_FR : pe ? EV_PAR : EV_OVR;
        if ((sel ? exp_p.size() : exp_n.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_unexpected: got event %0d expected none (cycle %0d)",
                     sel ? "p" : "n", kind, cyc);
            return;
        end
        e = sel ? exp_p.pop_front() : exp_n.pop_front();
        check(sel ? "p_event_kind" : "n_event_kind", kind, e.kind);
        if (e.kind == EV_WR && kind == EV_WR)
            check(sel ? "p_wdata" : "n_wdata", wd, e.data);
    endtask

    always @(negedge WCLK) begin
        if (!WRST) begin
            if (if_n.WEo) last_we_cyc_n = cyc;
            observe(1'b0, if_n.WEo, if_n.WDo, if_n.FRAME_ERRo, if_n.PARITY_ERRo, if_n.OVERRUNo);
            observe(1'b1, if_p.WEo, if_p.WDo, if_p.FRAME_ERRo, if_p.PARITY_ERRo, if_p.OVERRUNo);
        end
    end

    task automatic push(input bit sel, input ev_kind_e kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        if (sel) exp_p.push_back(e);
        else     exp_n.push_back(e);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx_n = v;
        repeat (CPB) @(posedge WCLK);
        #1;
    endtask

    // Entered and left #1 after a rising edge; frames chain with no gap.
    task automatic send(input bit sel, input logic [7:0] data, input bit has_par,
                        input logic par, input logic stop, output int start_cyc);
        start_cyc = cyc;
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, data[i]);
        if (has_par) drive(sel, par);
        drive(sel, stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge WCLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_n.size() != 0 || exp_p.size() != 0); i++)
            @(posedge WCLK);
        #1;
        check("drain_n", exp_n.size(), 0);
        check("drain_p", exp_p.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        WRST = 1'b1;
        rx_n = 1'b1;
        rx_p = 1'b1;
        if_n.FULLi = 1'b0;
        if_p.FULLi = 1'b0;
        repeat (3) @(posedge WCLK);
        #1;
        check("rst_we",    if_n.WEo, 0);
        check("rst_wd",    if_n.WDo, 0);
        check("rst_busy",  if_n.BUSYo, 0);
        check("rst_flags", {if_n.FRAME_ERRo, if_n.PARITY_ERRo, if_n.OVERRUNo}, 0);
        check("rst_p_busy", if_p.BUSYo, 0);
        WRST = 1'b0;
        idle(4);
        check("idle_busy", if_n.BUSYo, 0);

        // 1: single 0xA5, strobe at start + 3 (sync+detect) + 8 + 9*16.
        push(0, EV_WR, 8'hA5);
        send(0, 8'hA5, 0, 0, 1, t0);
        idle(CPB);
        drain();
        check("t1_we_cycle", last_we_cyc_n, t0 + 3 + 8 + 9 * CPB);

        // 2: back-to-back frames.
        push(0, EV_WR, 8'h00);
        push(0, EV_WR, 8'hFF);
        push(0, EV_WR, 8'h55);
        send(0, 8'h00, 0, 0, 1, t0);
        send(0, 8'hFF, 0, 0, 1, t0);
        send(0, 8'h55, 0, 0, 1, t0);
        idle(CPB);
        drain();

        // 3: framing error, long break, recovery.
        push(0, EV_FR, 8'h00);
        send(0, 8'h3C, 0, 0, 0, t0);
        idle(40 * CPB);
        check("t3_busy_in_break", if_n.BUSYo, 1);
        drain();
        rx_n = 1'b1;
        idle(2 * CPB);
        check("t3_busy_after_release", if_n.BUSYo, 0);
        push(0, EV_WR, 8'h81);
        send(0, 8'h81, 0, 0, 1, t0);
        idle(CPB);
        drain();

        // 4: even parity on 0x07 (three ones -> parity bit must be 1).
        push(1, EV_PAR, 8'h00);
        send(1, 8'h07, 1, 0, 1, t0);
        push(1, EV_WR, 8'h07);
        send(1, 8'h07, 1, 1, 1, t0);
        idle(CPB);
        drain();

        // 5: overrun while FIFO full, WDo keeps the last written byte.
        if_n.FULLi = 1'b1;
        push(0, EV_OVR, 8'h00);
        send(0, 8'h42, 0, 0, 1, t0);
        idle(CPB);
        drain();
        check("t5_wd_held", if_n.WDo, 8'h81);
        if_n.FULLi = 1'b0;
        push(0, EV_WR, 8'h43);
        send(0, 8'h43, 0, 0, 1, t0);
        idle(CPB);
        drain();

        // 6a: 4-cycle low glitch -> START briefly, back to IDLE, no event.
        rx_n = 1'b0;
        idle(4);
        rx_n = 1'b1;
        idle(2);
        check("t6_glitch_busy", if_n.BUSYo, 1);
        idle(8);
        check("t6_glitch_idle", if_n.BUSYo, 0);

        // 6b: reset in the middle of the data bits.
        rx_n = 1'b0;
        idle(3 * CPB);
        check("t6_busy_mid_data", if_n.BUSYo, 1);
        #2 WRST = 1'b1;
        #1;
        check("t6_rst_busy", if_n.BUSYo, 0);
        check("t6_rst_wd",   if_n.WDo, 0);
        check("t6_rst_we",   if_n.WEo, 0);
        rx_n = 1'b1;
        idle(4);
        WRST = 1'b0;
        idle(2 * CPB);
        push(0, EV_WR, 8'h99);
        send(0, 8'h99, 0, 0, 1, t0);
        idle(CPB);
        drain();
        check("final_wd", if_n.WDo, 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_uart_rx_deserializer
